// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the MIPS execution-trace buffer.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALTED  = 2'd2
  } trace_state_t;

  localparam logic [1:0] CAUSE_STALL   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Bit positions inside the 8-bit control bundle from the core's decoder.
  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_JUMP     = 6;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGWRITE = 0;

  // Entry fields are sized for the widest supported core; narrower PCs are zero-extended.
  localparam int TRACE_PC_W    = 32;
  localparam int TRACE_INSTR_W = 32;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]    pc;
    logic [TRACE_INSTR_W-1:0] instr;
    logic [7:0]               ctrl;
    logic                     zero;
  } trace_entry_t;

endpackage

// File: rtl/mips_trace_buffer_ram.sv
// Trace storage: one synchronous write port, one registered read port.
module trace_ram
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_entry_t             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_entry_t             rdata
);

  trace_entry_t mem [DEPTH];
  trace_entry_t rdata_q;

  // NOTE: the array itself is not reset so it maps onto plain RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips_trace_buffer.sv
// Circular execution-trace capture with PC-stall / cycle-budget halt detection and read drain.
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int INSTR_W     = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 64,
  parameter int STALL_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [PC_W-1:0]            pc,
  input  logic [INSTR_W-1:0]         instruction,
  input  logic [7:0]                 ctrl,
  input  logic                       zero,
  input  logic                       arm,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [PC_W-1:0]            rd_pc,
  output logic [INSTR_W-1:0]         rd_instr,
  output logic [7:0]                 rd_ctrl,
  output logic                       rd_zero,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       done,
  output logic [1:0]                 done_cause,
  output logic                       busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CYW = $clog2(MAX_CYCLES + 1);
  localparam int SW  = $clog2(STALL_LIMIT + 1);

  localparam logic [CW-1:0]  FULL      = CW'(DEPTH);
  localparam logic [CYW-1:0] CYC_LIMIT = CYW'(MAX_CYCLES);
  localparam logic [SW-1:0]  STL_LIMIT = SW'(STALL_LIMIT);

  trace_state_t    state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CYW-1:0]  cyc_q, cyc_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [PC_W-1:0] last_pc_q, last_pc_d;
  logic            have_prev_q, have_prev_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic [1:0]      cause_q, cause_d;
  logic            rd_valid_q, rd_valid_d;

  logic            ram_we, ram_re, halt_stall, halt_timeout;
  trace_entry_t    wr_entry, rd_entry;

  assign wr_entry = '{pc: TRACE_PC_W'(pc), instr: TRACE_INSTR_W'(instruction), ctrl: ctrl, zero: zero};

  // NOTE: every signal gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    cyc_d        = cyc_q;
    stall_d      = stall_q;
    last_pc_d    = last_pc_q;
    have_prev_d  = have_prev_q;
    overflow_d   = overflow_q;
    done_d       = done_q;
    cause_d      = cause_q;
    rd_valid_d   = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    halt_stall   = 1'b0;
    halt_timeout = 1'b0;

    // Arming from IDLE or HALTED starts a fresh capture and beats any pending pop.
    if (arm && state_q != ST_CAPTURE) begin
      state_d     = ST_CAPTURE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      cyc_d       = '0;
      stall_d     = '0;
      have_prev_d = 1'b0;
      overflow_d  = 1'b0;
      done_d      = 1'b0;
      cause_d     = 2'b00;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (enable) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cyc_d    = cyc_q + CYW'(1);
            if (count_q == FULL) begin
              rd_ptr_d   = rd_ptr_q + AW'(1);
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
            stall_d      = (have_prev_q && pc == last_pc_q) ? stall_q + SW'(1) : '0;
            last_pc_d    = pc;
            have_prev_d  = 1'b1;
            halt_stall   = (stall_d == STL_LIMIT);
            halt_timeout = (cyc_d == CYC_LIMIT);
            if (halt_stall || halt_timeout) begin
              state_d = ST_HALTED;
              done_d  = 1'b1;
              cause_d = (halt_stall ? CAUSE_STALL : 2'b00) | (halt_timeout ? CAUSE_TIMEOUT : 2'b00);
            end
          end
        end
        ST_HALTED: begin
          if (rd_req && count_q != '0) begin
            ram_re     = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
            count_d    = count_q - CW'(1);
            rd_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cyc_q       <= '0;
      stall_q     <= '0;
      last_pc_q   <= '0;
      have_prev_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= 2'b00;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cyc_q       <= cyc_d;
      stall_q     <= stall_d;
      last_pc_q   <= last_pc_d;
      have_prev_q <= have_prev_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign rd_valid   = rd_valid_q;
  assign rd_pc      = rd_entry.pc[PC_W-1:0];
  assign rd_instr   = rd_entry.instr[INSTR_W-1:0];
  assign rd_ctrl    = rd_entry.ctrl;
  assign rd_zero    = rd_entry.zero;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign done       = done_q;
  assign done_cause = cause_q;
  assign busy       = (state_q == ST_CAPTURE);

endmodule
